// File: rtl/img_out_writeback.sv
// Output-image writeback: captures CPU stores that hit the output-image window,
// buffers them in a small FIFO and drains them as byte writes into the image RAM.
// Tracks written pixels and flags image completion and dropped stores.
module img_out_writeback #(
    parameter logic [31:0] OUT_BASE   = 32'd262144,
    parameter logic [31:0] WIN_SIZE   = 32'd65536,
    parameter int unsigned DEPTH      = 8,
    parameter logic [31:0] IMG_PIXELS = 32'd65536
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] data_mem_address_i,
    input  logic [31:0] data_mem_in_data_i,
    input  logic        data_mem_WE_i,
    output logic        cpu_stall_o,
    output logic [15:0] ram_address_o,
    output logic [7:0]  ram_data_o,
    output logic        ram_wren_o,
    input  logic        ram_ready_i,
    output logic [31:0] pixel_count_o,
    output logic        done_o,
    output logic        overflow_o,
    input  logic        clear_i
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {StIdle, StDrain, StDone} state_e;

    state_e           state_q;
    logic             done_q;
    logic             ovf_q;
    logic [31:0]      pix_q, pix_d;
    logic [CNT_W-1:0] occ_q, occ_d;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [23:0]      mem_q [DEPTH];

    logic [31:0] offset;
    logic        hit, full, empty, pop, push, drop;
    logic [23:0] head;

    // Upper store data bits are never written to the image.
    logic unused_data;
    assign unused_data = ^data_mem_in_data_i[31:8];

    // Offset wraps for addresses below the base, so the lower bound check is still needed.
    assign offset = data_mem_address_i - OUT_BASE;
    assign hit    = data_mem_WE_i && (data_mem_address_i >= OUT_BASE) && (offset < WIN_SIZE);

    assign full  = (occ_q == FULL_CNT);
    assign empty = (occ_q == '0);
    assign pop   = ram_wren_o && ram_ready_i;
    // A full FIFO can still accept when the head leaves in the same cycle.
    assign push  = hit && !clear_i && (!full || pop);
    assign drop  = hit && !clear_i && full && !pop;

    assign head          = mem_q[rd_ptr_q];
    assign ram_wren_o    = !empty;
    assign ram_address_o = empty ? 16'h0 : head[23:8];
    assign ram_data_o    = empty ? 8'h0 : head[7:0];
    assign cpu_stall_o   = full;
    assign pixel_count_o = pix_q;
    assign done_o        = done_q;
    assign overflow_o    = ovf_q;

    // Next occupancy and saturating pixel count.
    always_comb begin
        occ_d = occ_q;
        unique case ({push, pop})
            2'b10:   occ_d = occ_q + CNT_W'(1);
            2'b01:   occ_d = occ_q - CNT_W'(1);
            default: occ_d = occ_q;
        endcase
        pix_d = pix_q;
        if (pop && (pix_q != 32'hFFFF_FFFF)) begin
            pix_d = pix_q + 32'd1;
        end
    end

    // FIFO storage; contents need no reset since occupancy gates their use.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {offset[15:0], data_mem_in_data_i[7:0]};
        end
    end

    // FIFO pointers, occupancy, pixel counter and sticky overflow.
    always_ff @(posedge CLK) begin
        if (!RST || clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            pix_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            occ_q <= occ_d;
            pix_q <= pix_d;
            if (drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Image-progress FSM with registered done flag.
    always_ff @(posedge CLK) begin
        if (!RST || clear_i) begin
            state_q <= StIdle;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (push) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    // Completion is judged on post-update count and occupancy.
                    if ((pix_d >= IMG_PIXELS) && (occ_d == '0)) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end
                end
                StDone: begin
                    done_q <= 1'b1;
                end
                default: begin
                    state_q <= StIdle;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_img_out_writeback.sv
// Self-checking bench for img_out_writeback: queue-based reference model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_img_out_writeback;

    localparam int unsigned DEPTH = 8;
    localparam logic [31:0] BASE  = 32'd262144;
    localparam longint unsigned WIN = 65536;
    localparam longint unsigned IMG = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [31:0] data_mem_address_i = '0;
    logic [31:0] data_mem_in_data_i = '0;
    logic        data_mem_WE_i = 1'b0;
    logic        cpu_stall_o;
    logic [15:0] ram_address_o;
    logic [7:0]  ram_data_o;
    logic        ram_wren_o;
    logic        ram_ready_i = 1'b0;
    logic [31:0] pixel_count_o;
    logic        done_o;
    logic        overflow_o;
    logic        clear_i = 1'b0;

    img_out_writeback #(
        .OUT_BASE  (BASE),
        .WIN_SIZE  (32'd65536),
        .DEPTH     (DEPTH),
        .IMG_PIXELS(32'd4)
    ) dut (
        .CLK               (CLK),
        .RST               (RST),
        .data_mem_address_i(data_mem_address_i),
        .data_mem_in_data_i(data_mem_in_data_i),
        .data_mem_WE_i     (data_mem_WE_i),
        .cpu_stall_o       (cpu_stall_o),
        .ram_address_o     (ram_address_o),
        .ram_data_o        (ram_data_o),
        .ram_wren_o        (ram_wren_o),
        .ram_ready_i       (ram_ready_i),
        .pixel_count_o     (pixel_count_o),
        .done_o            (done_o),
        .overflow_o        (overflow_o),
        .clear_i           (clear_i)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO contents as a queue of {offset, byte}.
    logic [23:0]     q[$];
    longint unsigned m_cnt = 0;
    bit              m_done = 1'b0;
    bit              m_ovf = 1'b0;
    bit              m_valid = 1'b0;

    always @(posedge CLK) begin
        bit              m_pop;
        bit              m_hit;
        longint unsigned a;
        if (!RST || clear_i) begin
            q.delete();
            m_cnt   = 0;
            m_done  = 1'b0;
            m_ovf   = 1'b0;
            m_valid = 1'b1;
        end else begin
            m_pop = (q.size() != 0) && ram_ready_i;
            a     = longint'(data_mem_address_i);
            m_hit = data_mem_WE_i && (a >= longint'(BASE)) && (a < longint'(BASE) + WIN);
            if (m_hit && (q.size() == DEPTH) && !m_pop) begin
                m_ovf = 1'b1;
                m_hit = 1'b0;
            end
            if (m_pop) begin
                void'(q.pop_front());
                if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
            end
            if (m_hit) begin
                q.push_back({16'(a - longint'(BASE)), data_mem_in_data_i[7:0]});
            end
            if ((m_cnt >= IMG) && (q.size() == 0)) m_done = 1'b1;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge CLK) begin
        if (m_valid) begin
            chk("wren", 32'(ram_wren_o), 32'(q.size() != 0));
            chk("stall", 32'(cpu_stall_o), 32'(q.size() == DEPTH));
            chk("count", pixel_count_o, m_cnt[31:0]);
            chk("done", 32'(done_o), 32'(m_done));
            chk("overflow", 32'(overflow_o), 32'(m_ovf));
            if (q.size() != 0) begin
                chk("addr", 32'(ram_address_o), 32'(q[0][23:8]));
                chk("data", 32'(ram_data_o), 32'(q[0][7:0]));
            end
        end
    end

    task automatic cyc(input bit we, input logic [31:0] addr, input logic [31:0] data,
                       input bit rdy, input bit clr, input bit rst_n);
        data_mem_WE_i      = we;
        data_mem_address_i = addr;
        data_mem_in_data_i = data;
        ram_ready_i        = rdy;
        clear_i            = clr;
        RST                = rst_n;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input bit rdy);
        cyc(1'b0, 32'h0, 32'h0, rdy, 1'b0, 1'b1);
    endtask

    task automatic st(input int unsigned off, input logic [7:0] d, input bit rdy);
        cyc(1'b1, BASE + off, {24'h0, d}, rdy, 1'b0, 1'b1);
    endtask

    task automatic clr();
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        logic [31:0] edges [6];
        logic [31:0] a;
        int          sel;

        edges[0] = BASE - 32'd1;
        edges[1] = BASE;
        edges[2] = BASE + 32'd65535;
        edges[3] = BASE + 32'd65536;
        edges[4] = 32'h0;
        edges[5] = 32'hFFFF_FFFF;

        // Reset
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("rst_wren", 32'(ram_wren_o), 32'd0);
        chk("rst_stall", 32'(cpu_stall_o), 32'd0);
        chk("rst_count", pixel_count_o, 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_ovf", 32'(overflow_o), 32'd0);
        chk("rst_addr", 32'(ram_address_o), 32'd0);

        // Single store
        cyc(1'b1, BASE + 32'd5, 32'h1AB, 1'b1, 1'b0, 1'b1);
        chk("single_wren", 32'(ram_wren_o), 32'd1);
        chk("single_addr", 32'(ram_address_o), 32'd5);
        chk("single_data", 32'(ram_data_o), 32'hAB);
        idle(1'b1);
        chk("single_count", pixel_count_o, 32'd1);
        chk("single_wren_off", 32'(ram_wren_o), 32'd0);

        // Window filter
        cyc(1'b1, 32'd4095, 32'h11, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 32'd262143, 32'h22, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, BASE + 32'd65536, 32'h33, 1'b1, 1'b0, 1'b1);
        chk("filter_none", 32'(ram_wren_o), 32'd0);
        cyc(1'b1, BASE, 32'h5A, 1'b1, 1'b0, 1'b1);
        chk("filter_wren", 32'(ram_wren_o), 32'd1);
        chk("filter_addr", 32'(ram_address_o), 32'd0);
        idle(1'b1);
        chk("filter_count", pixel_count_o, 32'd2);
        chk("filter_ovf", 32'(overflow_o), 32'd0);

        // Back-pressure, overflow, ordered drain
        clr();
        chk("clear_count", pixel_count_o, 32'd0);
        for (int i = 0; i < 8; i++) st(10 + i, 8'(8'h10 + i), 1'b0);
        chk("bp_stall", 32'(cpu_stall_o), 32'd1);
        chk("bp_ovf0", 32'(overflow_o), 32'd0);
        st(50, 8'hEE, 1'b0);
        chk("bp_ovf1", 32'(overflow_o), 32'd1);
        for (int i = 0; i < 8; i++) begin
            chk("bp_order_addr", 32'(ram_address_o), 32'(10 + i));
            chk("bp_order_data", 32'(ram_data_o), 32'(8'h10 + i));
            idle(1'b1);
            if (i == 0) chk("bp_unstall", 32'(cpu_stall_o), 32'd0);
        end
        chk("bp_empty", 32'(ram_wren_o), 32'd0);
        chk("bp_count", pixel_count_o, 32'd8);

        // Full with simultaneous pop
        clr();
        for (int i = 0; i < 8; i++) st(20 + i, 8'(i), 1'b0);
        cyc(1'b1, BASE + 32'd100, 32'h64, 1'b1, 1'b0, 1'b1);
        chk("fp_stall", 32'(cpu_stall_o), 32'd1);
        chk("fp_ovf", 32'(overflow_o), 32'd0);
        chk("fp_head", 32'(ram_address_o), 32'd21);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) chk("fp_last", 32'(ram_address_o), 32'd100);
            idle(1'b1);
        end
        chk("fp_count", pixel_count_o, 32'd9);

        // Completion
        clr();
        for (int i = 0; i < 4; i++) st(i, 8'(8'hC0 + i), 1'b1);
        chk("done_early", 32'(done_o), 32'd0);
        idle(1'b1);
        chk("done_set", 32'(done_o), 32'd1);
        chk("done_count", pixel_count_o, 32'd4);
        st(4, 8'hC4, 1'b1);
        idle(1'b1);
        chk("done_count5", pixel_count_o, 32'd5);
        chk("done_hold", 32'(done_o), 32'd1);

        // Clear mid-drain with a coincident hit
        clr();
        for (int i = 0; i < 9; i++) st(30 + i, 8'(i), 1'b0);
        chk("cl_ovf_pre", 32'(overflow_o), 32'd1);
        cyc(1'b1, BASE + 32'd7, 32'h77, 1'b0, 1'b1, 1'b1);
        chk("cl_wren", 32'(ram_wren_o), 32'd0);
        chk("cl_count", pixel_count_o, 32'd0);
        chk("cl_ovf", 32'(overflow_o), 32'd0);
        chk("cl_stall", 32'(cpu_stall_o), 32'd0);
        idle(1'b0);
        chk("cl_hit_dropped", 32'(ram_wren_o), 32'd0);

        // Reset mid-drain
        st(1, 8'h01, 1'b1);
        idle(1'b1);
        chk("rm_count_pre", pixel_count_o, 32'd1);
        for (int i = 0; i < 3; i++) st(40 + i, 8'(i), 1'b0);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("rm_wren", 32'(ram_wren_o), 32'd0);
        chk("rm_count", pixel_count_o, 32'd0);
        idle(1'b1);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 6)      a = BASE + $urandom_range(0, 65535);
            else if (sel < 8) a = edges[$urandom_range(0, 5)];
            else              a = $urandom;
            cyc($urandom_range(0, 1) == 1, a, $urandom,
                $urandom_range(0, 9) < 6,
                $urandom_range(0, 199) == 0,
                $urandom_range(0, 499) != 0);
        end
        for (int i = 0; i < 12; i++) idle(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/img_out_writeback.md
Name: img_out_writeback

Overview:
- Sits directly downstream of the CPU data-memory write port (data_mem_address_o / data_mem_in_data_o / data_mem_WE_o).
- Captures every CPU store that falls inside the output-image address window and buffers it in a small FIFO.
- Drains the buffered stores as byte writes into the 16-bit-addressed output image RAM, with back-pressure from the RAM side and a stall request to the CPU.
- Counts written pixels and flags completion and overflow.

Parameters:
- OUT_BASE, 32'd262144, first byte address of output image window.
- WIN_SIZE, 32'd65536, window size in bytes; valid offsets are 0..WIN_SIZE-1.
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- IMG_PIXELS, 32'd65536, number of pixel writes that completes one image.

Ports:
- CLK  in  1  clock; all logic on posedge.
- RST  in  1  synchronous reset, active-low.
- data_mem_address_i  in  32  CPU store address.
- data_mem_in_data_i  in  32  CPU store data; only [7:0] is used.
- data_mem_WE_i  in  1  CPU store strobe, one store per high cycle.
- cpu_stall_o  out  1  high while FIFO full; the CPU must hold its store.
- ram_address_o  out  16  image RAM byte address (window offset).
- ram_data_o  out  8  pixel byte.
- ram_wren_o  out  1  write valid to image RAM.
- ram_ready_i  in  1  RAM accepts the write this cycle when ram_wren_o=1.
- pixel_count_o  out  32  number of completed RAM writes since reset or clear.
- done_o  out  1  image complete.
- overflow_o  out  1  sticky: an in-window store was dropped.
- clear_i  in  1  synchronous soft clear of counters, flags and FIFO.

Behaviour:
- Reset (RST=0 at posedge) values:
  - All outputs 0.
  - FIFO empty; read/write pointers 0; FSM in IDLE.
- Window hit:
  - hit = data_mem_WE_i && (addr >= OUT_BASE) && (addr - OUT_BASE < WIN_SIZE).
  - The comparison is unsigned 32-bit.
  - Entry = {offset[15:0], data[7:0]}.
  - Out-of-window stores are ignored and have no side effects.
- Push rule:
  - Push on hit when not full, or when full and a pop occurs in the same cycle.
  - A hit while full with no pop drops the entry and sets overflow_o on the next cycle. overflow_o holds until reset or clear_i.
- Pop rule: pop when ram_wren_o && ram_ready_i.
- cpu_stall_o = full (registered count == DEPTH). It is combinational from the occupancy register.
- Output registration: ram_address_o and ram_data_o present the FIFO head; ram_wren_o = !empty.
- Latency: a store accepted at edge N is visible on ram_wren_o after edge N (earliest write cycle N+1).
- Ordering and retry:
  - FIFO order is strictly preserved.
  - Head data is held stable while ram_wren_o=1 && ram_ready_i=0.
- Occupancy:
  - Simultaneous push and pop leaves occupancy unchanged.
  - Pointers wrap modulo DEPTH.
- pixel_count_o increments by 1 per pop and saturates at 32'hFFFFFFFF.
- FSM:
  - IDLE → DRAIN on the first push.
  - DRAIN → DONE when pixel_count reaches IMG_PIXELS, evaluated after the increment, and the FIFO is empty.
  - DRAIN stays in DRAIN otherwise. DRAIN does not return to IDLE when the FIFO empties mid-image.
  - DONE: done_o=1. Further hits are still pushed and drained, and counted. done_o stays 1.
  - Any state → IDLE on clear_i.
- clear_i (RST high):
  - Empties the FIFO and zeroes pixel_count_o, done_o and overflow_o next cycle.
  - A hit in the same cycle as clear_i is discarded.
- Reset mid-operation: buffered entries are discarded and no partial RAM write is completed. ram_wren_o=0 in the cycle after reset is sampled.

Test Plan:
- Single store: addr=262144+5, data=32'h1AB, ready=1 → next cycle ram_wren_o=1, ram_address_o=5, ram_data_o=8'hAB; pixel_count_o=1 one cycle later.
- Window filter: stores to 4095, 262143, 262144+65536 and 262144 → exactly one RAM write, address 0; overflow_o=0.
- Back-pressure: ready=0 and 8 in-window stores → cpu_stall_o=1 after the 8th. A 9th store without a pop → overflow_o=1. Ready=1 → 8 writes in order, stall deasserts after the first pop.
- Full with simultaneous pop: FIFO full, ready=1 and a hit in the same cycle → entry accepted, occupancy stays 8, overflow_o=0.
- Completion: IMG_PIXELS=4, four stores to offsets 0..3 → done_o=1 after the 4th write drains. A 5th store → still written, pixel_count_o=5, done_o=1.
- Clear/reset mid-drain: ready=0 with 3 entries buffered, then clear_i=1 (or RST=0) → next cycle ram_wren_o=0, pixel_count_o=0, overflow_o=0, FSM in IDLE.
